// File: rtl/reduce_port_sched.sv
// Round-robin scheduler sharing one reduction path among the per-port reduce FIFOs.
// Pops at most one non-empty port per cycle, gated by credits that mirror downstream free space.
module reduce_port_sched #(
  parameter int NUM_PORTS = 6,
  parameter int FLIT_W    = 85,
  parameter int CREDITS   = 10,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_PORTS-1:0]        req_nempty,
  input  logic [NUM_PORTS*FLIT_W-1:0] req_flit,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [FLIT_W-1:0]           out_flit,
  output logic                        out_valid,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        down_rd,
  output logic [CNT_W-1:0]            credits,
  output logic                        idle
);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  state_t                   state, state_nxt;
  logic [SEL_W-1:0]         rr_ptr, rr_nxt;
  logic [SEL_W-1:0]         win_p0;
  logic [FLIT_W-1:0]        flit_p0;
  logic                     any_req;
  logic                     issue_p0;
  logic [CNT_W-1:0]         cred_nxt;
  logic                     cred_ovf;
  logic                     cred_err;
  logic [2*NUM_PORTS-1:0]   req_rot;
  logic [SEL_W-1:0]         win_off;
  logic [SEL_W:0]           win_sum;

  assign any_req  = |req_nempty;
  assign issue_p0 = (state == ISSUE) && en && (credits != '0) && any_req;

  // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, then map back.
  always_comb begin
    req_rot = {req_nempty, req_nempty} >> rr_ptr;
    win_off = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = SEL_W'(k);
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= (SEL_W+1)'(NUM_PORTS)) win_sum = win_sum - (SEL_W+1)'(NUM_PORTS);
    win_p0 = win_sum[SEL_W-1:0];
    rr_nxt = (win_p0 == SEL_W'(NUM_PORTS - 1)) ? '0 : win_p0 + SEL_W'(1);
  end

  always_comb begin
    grant   = '0;
    flit_p0 = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_p0 == SEL_W'(i)) begin
        grant[i] = issue_p0;
        flit_p0  = req_flit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  // A return at full count has nowhere to go; it is dropped and flagged.
  always_comb begin
    cred_nxt = credits;
    cred_ovf = 1'b0;
    if (issue_p0 && !down_rd) begin
      cred_nxt = credits - CNT_W'(1);
    end else if (!issue_p0 && down_rd) begin
      if (credits == CNT_W'(CREDITS)) cred_ovf = 1'b1;
      else                            cred_nxt = credits + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && any_req) state_nxt = ISSUE;
      ISSUE: begin
        if (!en)                  state_nxt = IDLE;
        else if (cred_nxt == '0)  state_nxt = STALL;
        else if (!any_req)        state_nxt = IDLE;
      end
      STALL: begin
        if (!en)                  state_nxt = IDLE;
        else if (credits != '0)   state_nxt = ISSUE;
      end
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      credits   <= CNT_W'(CREDITS);
      cred_err  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      credits   <= cred_nxt;
      cred_err  <= cred_err | cred_ovf;
      out_valid <= issue_p0;
      if (issue_p0) rr_ptr <= rr_nxt;
    end
  end

  // Output stage: registered flit and source index, held between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flit <= '0;
      out_sel  <= '0;
    end else if (issue_p0) begin
      out_flit <= flit_p0;
      out_sel  <= win_p0;
    end
  end

  assign idle = (state == IDLE) && !out_valid;

endmodule

// File: tb/tb_reduce_port_sched.sv
// Bench for reduce_port_sched: directed stimulus pushes expected ports into a queue,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_reduce_port_sched;
  localparam int NP = 6;
  localparam int FW = 85;
  localparam int SW = 3;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NP-1:0]    req_nempty;
  logic [NP*FW-1:0] req_flit;
  logic [NP-1:0]    grant;
  logic [FW-1:0]    out_flit;
  logic             out_valid;
  logic [SW-1:0]    out_sel;
  logic             down_rd;
  logic [CW-1:0]    credits;
  logic             idle;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  reduce_port_sched #(.NUM_PORTS(NP), .FLIT_W(FW), .CREDITS(10), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_nempty(req_nempty), .req_flit(req_flit),
    .grant(grant), .out_flit(out_flit), .out_valid(out_valid), .out_sel(out_sel),
    .down_rd(down_rd), .credits(credits), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] flit_of(input int p);
    logic [7:0] b;
    b = 8'(p);
    return {16'hC0DE, b, 61'(p * 37 + 5)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [NP-1:0] r, input logic d);
    @(negedge clk);
    en = e;
    req_nempty = r;
    down_rd = d;
    #1;
  endtask

  // p < 0 means no grant expected this cycle
  task automatic exp_grant(input string name, input int p);
    logic [NP-1:0] oh;
    if (p < 0) begin
      check(name, grant, 0);
    end else begin
      oh = NP'(1) << p;
      check(name, grant, oh);
      exp_q.push_back(p);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    req_nempty = '0;
    down_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        int p;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got sel %0d, expected no output", out_sel);
        end else begin
          p = exp_q.pop_front();
          check("out_sel", out_sel, p);
          check("out_flit", out_flit, flit_of(p));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    req_nempty = '0;
    down_rd = 1'b0;
    for (int i = 0; i < NP; i++) req_flit[i*FW +: FW] = flit_of(i);

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_valid", out_valid, 0);
    check("rst_credits", credits, 10);
    check("rst_idle", idle, 1);
    check("rst_sel", out_sel, 0);
    check("rst_flit", out_flit, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, '0, 1'b0);
      check("noreq_grant", grant, 0);
      check("noreq_valid", out_valid, 0);
      check("noreq_credits", credits, 10);
      check("noreq_idle", idle, 1);
    end

    // Two ports alternating with a return every cycle
    drive(1'b1, 6'b000011, 1'b0);
    exp_grant("t2_first", -1);
    drive(1'b1, 6'b000011, 1'b0);
    exp_grant("t2_grant", 0);
    check("t2_cred0", credits, 10);
    for (int k = 1; k < 6; k++) begin
      drive(1'b1, 6'b000011, 1'b1);
      exp_grant("t2_grant", k % 2);
      check("t2_cred", credits, 9);
    end
    drive(1'b0, '0, 1'b1);
    exp_grant("t2_stop", -1);
    check("t2_cred_end", credits, 9);
    drive(1'b0, '0, 1'b0);
    check("t2_refill", credits, 10);
    check("t2_idle", idle, 1);
    drain("t2_drain");

    // All six ports, no returns: exhaust credits then stall
    do_reset();
    drive(1'b1, 6'h3F, 1'b0);
    exp_grant("t3_first", -1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 6'h3F, 1'b0);
      check("t3_cred", credits, 10 - k);
      exp_grant("t3_grant", k % 6);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 6'h3F, 1'b0);
      exp_grant("t3_stall", -1);
      check("t3_cred_zero", credits, 0);
      check("t3_not_idle", idle, 0);
    end
    drive(1'b1, 6'h3F, 1'b1);
    exp_grant("t3_zero_rd", -1);
    drive(1'b1, 6'h3F, 1'b0);
    exp_grant("t3_wake", -1);
    check("t3_cred_one", credits, 1);
    drive(1'b1, 6'h3F, 1'b0);
    exp_grant("t3_resume", 4);
    drive(1'b1, 6'h3F, 1'b0);
    exp_grant("t3_restall", -1);
    check("t3_cred_rezero", credits, 0);

    // Same-cycle issue and return at one credit keeps streaming
    drive(1'b1, 6'h3F, 1'b1);
    exp_grant("t4_stall", -1);
    drive(1'b1, 6'h3F, 1'b0);
    exp_grant("t4_wake", -1);
    check("t4_cred_one", credits, 1);
    drive(1'b1, 6'h3F, 1'b1);
    exp_grant("t4_grant", 5);
    check("t4_cred", credits, 1);
    drive(1'b1, 6'h3F, 1'b1);
    exp_grant("t4_grant", 0);
    check("t4_cred", credits, 1);
    drive(1'b1, 6'h3F, 1'b1);
    exp_grant("t4_grant", 1);
    check("t4_cred", credits, 1);
    drive(1'b0, '0, 1'b0);
    exp_grant("t4_stop", -1);
    drain("t4_drain");

    // Enable dropped right after a grant
    do_reset();
    drive(1'b1, 6'b000100, 1'b0);
    exp_grant("t5_first", -1);
    drive(1'b1, 6'b000100, 1'b0);
    exp_grant("t5_grant", 2);
    drive(1'b0, 6'b000100, 1'b0);
    exp_grant("t5_off", -1);
    check("t5_valid", out_valid, 1);
    check("t5_busy", idle, 0);
    drive(1'b0, 6'b000100, 1'b0);
    exp_grant("t5_off2", -1);
    check("t5_valid_end", out_valid, 0);
    check("t5_idle", idle, 1);
    drain("t5_drain");

    // Asynchronous reset mid-burst at four credits
    do_reset();
    drive(1'b1, 6'h3F, 1'b0);
    exp_grant("t6_first", -1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 6'h3F, 1'b0);
      check("t6_cred", credits, 10 - k);
      exp_grant("t6_grant", k);
    end
    drive(1'b1, 6'h3F, 1'b0);
    check("t6_cred4", credits, 4);
    check("t6_grant_pre", grant, 6'b000001);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_credits", credits, 10);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_idle", idle, 1);
    check("t6_rst_sel", out_sel, 0);
    check("t6_rst_flit", out_flit, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 6'h3F, 1'b0);
    exp_grant("t6_after", 0);
    check("t6_after_cred", credits, 10);
    drive(1'b0, '0, 1'b0);
    exp_grant("t6_stop", -1);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduce_port_sched.md
# reduce_port_sched

Round-robin scheduler that shares the node's single reduction path among the per-port reduce FIFOs filled by the router's eject ports. Each cycle it picks at most one non-empty port FIFO and pops it. It forwards the flit, with its port index, into the reduce-unit input FIFO. Issue is gated by a credit counter that mirrors free space in that downstream FIFO. It sits between the per-port `large_buffer` reduce FIFOs and the reduce-unit FIFO, replacing priority-based selection with fair, flow-controlled arbitration.

## Interface
- `NUM_PORTS`, 6, number of requesting port FIFOs (xpos, ypos, zpos, xneg, yneg, zneg order; index 0 = xpos).
- `FLIT_W`, 85, flit-plus-children width: flit 82 plus `lg_numprocs` 3.
- `CREDITS`, 10, depth of the downstream reduce-unit FIFO.
- `SEL_W`, 3, width of port index; must satisfy 2^SEL_W ≥ NUM_PORTS.
- `CNT_W`, 4, credit counter width; must satisfy 2^CNT_W > CREDITS.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scheduling enable; low = drain and stop.
- `req_nempty` in NUM_PORTS: bit i high = port FIFO i non-empty.
- `req_flit` in NUM_PORTS*FLIT_W: show-ahead head flits; port i occupies bits [i*FLIT_W +: FLIT_W].
- `grant` out NUM_PORTS: one-hot pop strobe to port FIFO i (combinational, at most one bit high).
- `out_flit` out FLIT_W: registered flit to downstream FIFO write data.
- `out_valid` out 1: registered downstream write enable.
- `out_sel` out SEL_W: registered index of the port that supplied `out_flit`.
- `down_rd` in 1: downstream FIFO pop by reduce unit; returns one credit.
- `credits` out CNT_W: current credit count.
- `idle` out 1: high in state IDLE with no flit in flight.

## Operation
- States: IDLE, ISSUE, STALL.
- IDLE → ISSUE when `en` and any `req_nempty`.
- ISSUE → STALL when credits reach 0.
- ISSUE → IDLE when `en` low or no requests.
- STALL → ISSUE when credits > 0 and `en`.
- STALL → IDLE when `en` low.
- Issue condition in a cycle: state ISSUE, `en` high, credits > 0, and at least one `req_nempty`. Issue is evaluated combinationally in the current cycle.
- Winner: first set `req_nempty` bit searching upward from `rr_ptr`, wrapping past NUM_PORTS-1 to 0.
- On issue: `grant[winner]`=1 this cycle. Next edge: `out_flit`←`req_flit[winner]`, `out_sel`←winner, `out_valid`←1, `rr_ptr`←(winner+1) mod NUM_PORTS.
- No issue: `grant`=0, `out_valid`←0 next edge; `out_flit`/`out_sel` hold previous value.
- Credits: −1 on issue, +1 on `down_rd`, unchanged when both occur in the same cycle.
- Never issue with credits = 0, even if `down_rd` is high that cycle.
- Credits saturate at CREDITS: `down_rd` at full count is ignored and sets internal sticky `cred_err`, visible in sim only.
- `en` deassertion mid-stream: no new grants from the same cycle on. A flit already registered still emits `out_valid` on the next cycle.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, credits=CREDITS.
  - `out_valid`=0, `out_flit`=0, `out_sel`=0.
  - `grant`=0, `idle`=1.
- Reset is asynchronous and may assert mid-operation. It discards any in-flight registered flit and restores full credits.
- Grant-to-output latency: 1 cycle. `grant` in cycle t gives `out_valid`=1 in cycle t+1.
- Throughput: one flit per cycle sustained while credits > 0.
- First grant comes one cycle after requests appear from IDLE, because IDLE→ISSUE costs one cycle.
- `credits` is a registered output and reflects issues and returns from the previous cycle.
- `idle` = (state==IDLE) && !`out_valid`.

## Test plan
- Reset, no requests → `grant`=0, `out_valid`=0, `credits`=10, `idle`=1 indefinitely.
- `en`=1, `req_nempty`=6'b000011 held, `down_rd` pulsed every cycle:
  - `out_sel` sequence is 0,1,0,1… and each `out_flit` matches the granted port's `req_flit`.
  - Credits stay at 9 in steady state, after the first issue.
- All six ports requesting, `down_rd`=0:
  - Exactly 10 grants occur, in order 0..5,0..3.
  - Then state goes to STALL, credits=0, `grant`=0.
  - One `down_rd` pulse yields exactly one further grant, to port 4.
- Same-cycle issue and `down_rd` with credits=1 → credits stays 1. Issue continues without entering STALL.
- `en` dropped the cycle after a grant → that flit emits `out_valid` once, no further grants, state IDLE, `idle`=1 one cycle later.
- `rst` asserted mid-burst with credits=4 → outputs return to reset values immediately (asynchronously), credits=10, and first grant after release goes to port 0.
